universal_register_secded: RTL
==============================

Name: universal_register_secded

Overview:
- Parametrised successor of the 4-bit Hamming-protected universal shift register.
- Holds WIDTH data bits as a SEC-DED codeword; supports SISO, SIPO, PISO and PIPO modes with selectable shift direction.
- Every read and shift uses corrected data. Single-bit upsets are scrubbed back into storage automatically, and errors are flagged and counted.
- Sits between the serial/parallel datapath and the fault-monitor logic; includes a fault-injection port for verification.

Parameters:
- WIDTH, 8, data bits held.
- CNT_W, 8, width of the saturating corrected-error counter.
- P (localparam), derived, smallest P with 2^P >= WIDTH+P+1 (4 for WIDTH=8).
- CW (localparam), WIDTH+P+1, codeword width (13 for WIDTH=8).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  shift enable.
- mode  in  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO.
- dir  in  1  0 = shift left (serial_in to bit 0), 1 = shift right (serial_in to bit WIDTH-1).
- load  in  1  parallel load strobe.
- serial_in  in  1  serial data.
- parallel_in  in  WIDTH  parallel data.
- inj_en  in  1  fault-injection strobe.
- inj_mask  in  CW  XOR mask applied to the stored codeword.
- err_clr  in  1  clears err_uncorr and err_count.
- serial_out  out  1  output shift bit.
- parallel_out  out  WIDTH  corrected data.
- err_single  out  1  stored word currently has a correctable error.
- err_uncorr  out  1  sticky flag: a double error has been seen.
- err_count  out  CNT_W  saturating count of corrected errors.

Behaviour:
- Reset (rst=0, asynchronous):
  - Codeword = encode(0); err_uncorr = 0; err_count = 0.
  - Outputs follow combinationally: parallel_out = 0, serial_out = 0, err_single = 0.
- Codeword layout:
  - Bit 0 is overall even parity.
  - Positions 1..CW-1 use Hamming numbering: parity bits at powers of two, data bits in the remaining positions in ascending order, data LSB first.
- Decode (combinational, every cycle), with syndrome s and overall-parity mismatch m:
  - s=0, m=0: clean.
  - s!=0, m=1: single error at position s; flip it.
  - s=0, m=1: error in bit 0; data unaffected, counts as single.
  - s!=0, m=0: double error; data passed uncorrected.
- err_single = single-error condition (combinational). Decoded data d = corrected data bits.
- Write priority per edge, highest first:
  1. load=1 with mode 10 or 11: data <- parallel_in.
  2. enable=1 with mode 00/01/10: shift d by one toward dir, inserting serial_in.
  3. err_single=1: scrub, storage <- encode(d).
  4. Otherwise hold.
- Every write re-encodes. load is ignored in modes 00/01; enable is ignored in mode 11.
- Injection: next codeword = selected value XOR (inj_en ? inj_mask : 0). It applies on top of a same-cycle write.
- Outputs:
  - parallel_out = d in modes 01/11, else 0.
  - serial_out = d[WIDTH-1] when dir=0, d[0] when dir=1, in modes 00/10; else 0.
  - All outputs are combinational from storage, so there is zero-cycle read latency after an edge.
- err_count increments by 1 on each edge where err_single=1, saturating at 2^CNT_W-1. Scrub or write clears the error, so one upset is counted once.
- err_uncorr is set on any edge where a double error is decoded; it stays set until err_clr=1 or reset.
- err_clr: err_count <- 0 and err_uncorr <- 0. If err_clr and an error event occur on the same edge, clear wins.
- Mode change mid-shift takes effect on the next edge; stored data is unchanged.
- Reset mid-operation aborts the operation immediately.

Test Plan:
- SISO left (WIDTH=8): reset, mode=00, dir=0, enable=1, serial_in 1 then 0 -> parallel reads 0x01 then 0x02 (check via mode 11). serial_out=0 until 7 more shifts, then 1.
- PISO right: mode=10, load 0xB1, then enable 8 cycles, dir=1 -> serial_out sequence 1,0,0,0,1,1,0,1.
- Single upset: PIPO load 0xA5, then inj_en with one data-bit mask -> parallel_out stays 0xA5; err_single=1 for exactly one cycle; next-cycle codeword = encode(0xA5); err_count=1. Repeat with mask 0x001 (parity bit 0) -> same response, err_count=2.
- Double upset: load 0x3C, inject two-bit mask -> err_uncorr=1 and stays set. Load 0x3C again -> err_single=0, err_uncorr still 1. err_clr -> err_uncorr=0, err_count=0.
- Upset during shift: mode=01, enable=1, inject single data-bit error in the same cycle as a shift -> the next shift uses corrected data; final value matches a golden model. Also hold err_single every cycle with CNT_W=2 -> err_count saturates at 3.
- Async reset mid-shift: assert rst=0 between edges -> outputs go to 0 immediately, with no wait for a clock edge.

Source files
------------

// File: rtl/universal_register_secded.sv
// universal_register_secded
// WIDTH-bit universal shift register (SISO/SIPO/PISO/PIPO) whose storage is a
// SEC-DED codeword. Every read and shift uses corrected data. Single-bit
// upsets are scrubbed back into storage, and errors are flagged and counted.
// Bit 0 of the codeword is overall even parity. Positions 1..CW-1 follow
// Hamming numbering: parity at powers of two, data LSB-first in the rest.
module universal_register_secded #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  // Iterate P = clog2(WIDTH+P+1) from below to reach the smallest P with
  // 2^P >= WIDTH+P+1. It settles within these steps for practical widths.
  localparam int P0 = $clog2(WIDTH + 1),
  localparam int P1 = $clog2(WIDTH + P0 + 1),
  localparam int P  = $clog2(WIDTH + P1 + 1),
  localparam int CW = WIDTH + P + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             inj_en,
  input  logic [CW-1:0]    inj_mask,
  input  logic             err_clr,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             err_single,
  output logic             err_uncorr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    MODE_SISO = 2'b00,
    MODE_SIPO = 2'b01,
    MODE_PISO = 2'b10,
    MODE_PIPO = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Build a codeword: place the data bits, then fill each Hamming parity bit,
  // then set bit 0 so that the whole word has even parity.
  function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] value);
    logic [CW-1:0] cw;
    int j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = value[j];
        j++;
      end
    end
    for (int p = 0; p < P; p++) begin
      for (int pos = 1; pos < CW; pos++) begin
        if ((((pos >> p) & 1) == 1) && (pos != (1 << p))) begin
          cw[1 << p] = cw[1 << p] ^ cw[pos];
        end
      end
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  // Pull the data bits back out of the non-power-of-two positions.
  function automatic logic [WIDTH-1:0] extract(input logic [CW-1:0] cw);
    logic [WIDTH-1:0] value;
    int j;
    value = '0;
    j     = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        value[j] = cw[pos];
        j++;
      end
    end
    return value;
  endfunction

  mode_e            op;
  logic [CW-1:0]    codeword;
  logic [CW-1:0]    codeword_next;
  logic [CW-1:0]    written;
  logic [CW-1:0]    flip;
  logic [CW-1:0]    fixed_cw;
  logic [P-1:0]     syndrome;
  logic             parity_mismatch;
  logic             err_double;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;

  assign op = mode_e'(mode);

  // Decode the stored word: syndrome, overall parity, and single-bit repair.
  always_comb begin
    syndrome = '0;
    for (int p = 0; p < P; p++) begin
      for (int pos = 1; pos < CW; pos++) begin
        if (((pos >> p) & 1) == 1) begin
          syndrome[p] = syndrome[p] ^ codeword[pos];
        end
      end
    end
    parity_mismatch = ^codeword;
    flip = '0;
    if (parity_mismatch) begin
      if (syndrome == '0) begin
        flip[0] = 1'b1;
      end else if (int'(syndrome) < CW) begin
        flip[syndrome] = 1'b1;
      end
    end
    fixed_cw   = codeword ^ flip;
    data       = extract(fixed_cw);
    err_single = parity_mismatch;
    err_double = (syndrome != '0) && !parity_mismatch;
  end

  // One-position shift of the corrected data toward dir, inserting serial_in.
  always_comb begin
    if (dir) begin
      shifted = {serial_in, data[WIDTH-1:1]};
    end else begin
      shifted = {data[WIDTH-2:0], serial_in};
    end
  end

  // Pick load, shift, scrub or hold, then overlay any injected fault.
  always_comb begin
    written = codeword;
    if (load && (op == MODE_PISO || op == MODE_PIPO)) begin
      written = encode(parallel_in);
    end else if (enable && op != MODE_PIPO) begin
      written = encode(shifted);
    end else if (err_single) begin
      written = encode(data);
    end
    codeword_next = written ^ (inj_en ? inj_mask : '0);
  end

  // Mode-dependent views of the corrected data.
  always_comb begin
    parallel_out = '0;
    serial_out   = 1'b0;
    case (op)
      MODE_SIPO, MODE_PIPO: parallel_out = data;
      default:              serial_out = dir ? data[0] : data[WIDTH-1];
    endcase
  end

  // Protected storage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      codeword <= encode('0);
    end else begin
      codeword <= codeword_next;
    end
  end

  // Error bookkeeping: saturating corrected count and sticky double flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count  <= '0;
      err_uncorr <= 1'b0;
    end else if (err_clr) begin
      err_count  <= '0;
      err_uncorr <= 1'b0;
    end else begin
      if (err_single && err_count != CNT_MAX) begin
        err_count <= err_count + 1'b1;
      end
      if (err_double) begin
        err_uncorr <= 1'b1;
      end
    end
  end

endmodule
